ex_div_seq: RTL
===============

// Module: ex_div_seq
// PURPOSE
//  Multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU) beside the EX stage.
//  It takes forwarded rs1/rs2 operands, runs a radix-2 restoring divide, and
//  holds the pipeline with div_stall until the result is ready. The result
//  goes to the EX rd_data mux, and the pipeline latches it into MA in the DONE cycle.
// PARAMETERS
//  DW        32  operand/result width; iteration count = DW
//  FAST_SPC  1   1: divide-by-zero and overflow finish without CALC; 0: always iterate
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous active-high reset
//  flush        in   1   pipeline flush (rst_pipe), sync, aborts any operation
//  cmd_div_ex   in   1   divide-class op present in EX
//  div_code_ex  in   2   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  kill_ex      in   1   EX op purged (jmp_purge_ma); start suppressed
//  dc_stall     in   1   D-cache stall; freezes DONE hand-off
//  rs1_sel      in   DW  dividend (post-forwarding)
//  rs2_sel      in   DW  divisor (post-forwarding)
//  div_stall    out  1   hold IF/ID/EX; combinational from state and start
//  div_valid    out  1   div_rd_data valid this cycle (state DONE)
//  div_rd_data  out  DW  quotient or remainder, per latched div_code
// BEHAVIOUR
//  Reset/flush: state=IDLE, cnt=0, div_valid=0, div_rd_data=0, div_stall=0.
//   Takes priority over every other event.
//  start = (state==IDLE) & cmd_div_ex & ~kill_ex.
//  States:
//   IDLE -> start: latch code, signs, abs(operands); cnt=DW-1.
//    Go to DONE if FAST_SPC and special; otherwise go to CALC.
//   CALC: one restoring step per cycle. rem={rem[DW-2:0],q[DW-1]};
//    trial=rem-divisor (DW+1 bits). If no borrow, rem=trial and the q bit is 1.
//    cnt decrements; at cnt==0 go to FIX.
//   FIX: apply signs. Quotient negated if signed and sign(rs1)!=sign(rs2).
//    Remainder takes sign(rs1) if signed. Go to DONE.
//   DONE: div_valid=1, div_stall=0. Stay while dc_stall=1, holding data.
//    Go to IDLE when dc_stall=0. cmd_div_ex seen in DONE is the same
//    instruction and never restarts.
//  div_stall = start | CALC | FIX; it is low in IDLE without start and in DONE.
//  Latency from start cycle S: non-special valid at S+DW+2; fast special at S+1.
//  Special cases (RISC-V defined, also when FAST_SPC=0):
//   div by 0: quotient=all ones, remainder=rs1.
//   signed overflow (rs1=-2^(DW-1), rs2=-1): quotient=rs1, remainder=0.
//  Operands are captured at start; later rs1/rs2/code changes are ignored.
//  kill_ex only gates start; a running op is stopped only by flush/rst.
//  Back-to-back divides: IDLE between them costs 1 cycle, so the next start
//   is at the earliest DONE+1.
//  All arithmetic is unsigned on DW/DW+1 bits. Negation is two's complement
//   modulo 2^DW.
// TESTING
//  DIVU 100/7 -> div_stall high S..S+33, div_valid at S+34, data=14.
//  REM -7/2 -> data=0xFFFFFFFF (-1); DIV -7/2 -> data=0xFFFFFFFD (-3).
//  DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; with FAST_SPC=1, valid at S+1.
//  DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0.
//  Flush at S+10 -> next cycle IDLE, stall=0, valid=0; new DIVU 9/3 -> 3.
//  dc_stall=1 for 3 cycles in DONE -> valid and data held, no restart;
//   kill_ex=1 with cmd_div_ex -> no stall, no start.

Source files
------------

// File: rtl/ex_div_seq.sv
// ---------------------------------------------------------------------------
// ex_div_seq
//   Multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU) sitting beside the
//   EX stage. A divide-class op in EX starts a radix-2 restoring divide on the
//   forwarded operands. div_stall holds IF/ID/EX until the result is ready.
//   The result is presented for one DONE cycle, or for longer while the D-cache
//   stalls, so that the pipeline can latch it into MA.
//
// Parameters
//   DW        operand/result width; the divide iterates DW times
//   FAST_SPC  1: divide-by-zero and signed overflow skip the iterations
//
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   flush        in   pipeline flush; aborts any operation
//   cmd_div_ex   in   divide-class op present in EX
//   div_code_ex  in   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   kill_ex      in   EX op purged; suppresses start
//   dc_stall     in   D-cache stall; holds the DONE hand-off
//   rs1_sel      in   dividend (post-forwarding)
//   rs2_sel      in   divisor (post-forwarding)
//   div_stall    out  hold IF/ID/EX (start, CALC or FIX)
//   div_valid    out  div_rd_data valid (state DONE)
//   div_rd_data  out  quotient or remainder
// ---------------------------------------------------------------------------
module ex_div_seq #(
  parameter int DW       = 32,
  parameter bit FAST_SPC = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          cmd_div_ex,
  input  logic [1:0]    div_code_ex,
  input  logic          kill_ex,
  input  logic          dc_stall,
  input  logic [DW-1:0] rs1_sel,
  input  logic [DW-1:0] rs2_sel,
  output logic          div_stall,
  output logic          div_valid,
  output logic [DW-1:0] div_rd_data
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sel_rem;
  logic          neg_q;
  logic          neg_r;
  logic          zero_div;
  logic [DW-1:0] quo;
  logic [DW-1:0] rem;
  logic [DW-1:0] dvsr;

  logic          start;
  logic          signed_ex;
  logic          div0_ex;
  logic          ovf_ex;
  logic [DW-1:0] abs_rs1;
  logic [DW-1:0] abs_rs2;
  logic [DW-1:0] spec_res;
  logic [DW:0]   shifted;
  logic [DW:0]   trial;
  logic          borrow;
  logic [DW-1:0] rem_nxt;
  logic [DW-1:0] q_fix;
  logic [DW-1:0] r_fix;
  logic [DW-1:0] fix_res;

  assign start     = (state == IDLE) & cmd_div_ex & ~kill_ex;
  assign div_stall = start | (state == CALC) | (state == FIX);

  // Operand conditioning in the start cycle: magnitudes and special cases.
  always_comb begin
    signed_ex = ~div_code_ex[0];
    abs_rs1   = (signed_ex && rs1_sel[DW-1]) ? (~rs1_sel + 1'b1) : rs1_sel;
    abs_rs2   = (signed_ex && rs2_sel[DW-1]) ? (~rs2_sel + 1'b1) : rs2_sel;
    div0_ex   = (rs2_sel == '0);
    ovf_ex    = signed_ex && (rs1_sel == MIN_NEG) && (rs2_sel == '1);
    spec_res  = '0;
    if (div0_ex) begin
      spec_res = div_code_ex[1] ? rs1_sel : '1;
    end else if (ovf_ex) begin
      spec_res = div_code_ex[1] ? '0 : rs1_sel;
    end
  end

  // One restoring step. The partial remainder is shifted into DW+1 bits so
  // that divisors with the MSB set (unsigned) do not lose the top bit; a set
  // MSB in the trial difference means the subtraction borrowed.
  always_comb begin
    shifted = {rem, quo[DW-1]};
    trial   = shifted - {1'b0, dvsr};
    borrow  = trial[DW];
    rem_nxt = borrow ? shifted[DW-1:0] : trial[DW-1:0];
  end

  // Sign fix-up. Divide-by-zero forces an all-ones quotient regardless of the
  // operand signs; the remainder naturally comes back as rs1 after sign fix.
  always_comb begin
    q_fix   = zero_div ? '1 : (neg_q ? (~quo + 1'b1) : quo);
    r_fix   = neg_r ? (~rem + 1'b1) : rem;
    fix_res = sel_rem ? r_fix : q_fix;
  end

  // Sequencer: IDLE -> CALC (DW steps) -> FIX -> DONE, or IDLE -> DONE for
  // fast special cases. Reset and flush abort everything.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state       <= IDLE;
      cnt         <= '0;
      sel_rem     <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_div    <= 1'b0;
      quo         <= '0;
      rem         <= '0;
      dvsr        <= '0;
      div_valid   <= 1'b0;
      div_rd_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel_rem  <= div_code_ex[1];
            neg_q    <= signed_ex & (rs1_sel[DW-1] ^ rs2_sel[DW-1]);
            neg_r    <= signed_ex & rs1_sel[DW-1];
            zero_div <= div0_ex;
            quo      <= abs_rs1;
            rem      <= '0;
            dvsr     <= abs_rs2;
            cnt      <= CW'(DW - 1);
            if (FAST_SPC && (div0_ex || ovf_ex)) begin
              div_rd_data <= spec_res;
              div_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= {quo[DW-2:0], ~borrow};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          div_rd_data <= fix_res;
          div_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          // cmd_div_ex still high here is the same instruction; never restart.
          if (!dc_stall) begin
            div_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
